// File: rtl/tdm_demux7_pkg.sv
// Shared constants and state encoding for the 7-slot TDM receive path.
// The slot counter and the demux top both import this package.
package tdm_demux7_pkg;

  localparam int          NSLOT     = 7;
  localparam int          SLOT_W    = 3;
  localparam logic [2:0]  LAST_SLOT = 3'd6;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/slot_cnt7.sv
// Mod-7 slot counter: load0/load1 force a frame restart, inc steps 0..6 and wraps.
// The same unit can drive the transmit-side slot select.
module slot_cnt7
  import tdm_demux7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load0,
  input  logic              load1,
  output logic [SLOT_W-1:0] cnt
);

  logic [SLOT_W-1:0] cnt_r;

  // Slot position register; load0 beats load1, and both beat inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 3'd0;
    end else if (load0) begin
      cnt_r <= 3'd0;
    end else if (load1) begin
      cnt_r <= 3'd1;
    end else if (inc) begin
      cnt_r <= (cnt_r == LAST_SLOT) ? 3'd0 : cnt_r + 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/tdm_demux7.sv
// 1-to-7 TDM demultiplexer: locks to Fsync, collects seven serial bits per frame
// and presents them in parallel on A..G with a one-cycle Frame_valid strobe.
module tdm_demux7
  import tdm_demux7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic              Din,
  input  logic              Fsync,
  output logic [SLOT_W-1:0] Sel,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              D,
  output logic              E,
  output logic              F,
  output logic              G,
  output logic              Frame_valid,
  output logic              Sync_err,
  output logic              Locked
);

  state_t            state_r, state_s;
  logic [5:0]        hold_r, hold_s;
  logic [6:0]        out_r, out_s;
  logic              fv_r, fv_s;
  logic              se_r, se_s;
  logic              inc_s, load0_s, load1_s;
  logic [SLOT_W-1:0] cnt_s;

  slot_cnt7 u_slot_cnt7 (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_s),
    .load0 (load0_s),
    .load1 (load1_s),
    .cnt   (cnt_s)
  );

  // State, holding register, frame output and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HUNT;
      hold_r  <= 6'd0;
      out_r   <= 7'd0;
      fv_r    <= 1'b0;
      se_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      out_r   <= out_s;
      fv_r    <= fv_s;
      se_r    <= se_s;
    end
  end

  // Next-state, slot capture and pulse decisions for each enabled bit.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    out_s   = out_r;
    fv_s    = 1'b0;
    se_s    = 1'b0;
    inc_s   = 1'b0;
    load0_s = 1'b0;
    load1_s = 1'b0;
    if (En) begin
      case (state_r)
        HUNT: begin
          if (Fsync) begin
            hold_s  = {5'd0, Din};
            load1_s = 1'b1;
            state_s = LOCKED;
          end else begin
            state_s = HUNT;
          end
        end
        LOCKED: begin
          if (Fsync) begin
            // Sync anywhere but slot 0 abandons the partial frame and restarts here.
            se_s    = (cnt_s != 3'd0);
            hold_s  = {5'd0, Din};
            load1_s = 1'b1;
          end else if (cnt_s == 3'd0) begin
            se_s    = 1'b1;
            load0_s = 1'b1;
            state_s = HUNT;
          end else if (cnt_s == LAST_SLOT) begin
            out_s   = {Din, hold_r};
            fv_s    = 1'b1;
            inc_s   = 1'b1;
          end else begin
            hold_s[cnt_s] = Din;
            inc_s         = 1'b1;
          end
        end
        default: begin
          se_s    = 1'b1;
          load0_s = 1'b1;
          state_s = HUNT;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  assign Sel         = cnt_s;
  assign A           = out_r[0];
  assign B           = out_r[1];
  assign C           = out_r[2];
  assign D           = out_r[3];
  assign E           = out_r[4];
  assign F           = out_r[5];
  assign G           = out_r[6];
  assign Frame_valid = fv_r;
  assign Sync_err    = se_r;
  assign Locked      = (state_r == LOCKED);

endmodule

// File: tb/tb_tdm_demux7.sv
// Self-checking bench for tdm_demux7: directed test-plan sequences followed by
// randomized traffic, all compared against a frame-level reference model.
module tb_tdm_demux7;

  logic       clk = 1'b0;
  logic       rst, en, din, fsync;
  logic [2:0] sel;
  logic       a, b, c, d, e, f, g;
  logic       frame_valid, sync_err, locked;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame position as an integer, bits as plain arrays.
  bit m_locked;
  int m_pos;
  bit m_part [7];
  bit m_out  [7];
  bit m_fv, m_se;

  always #5 clk = ~clk;

  tdm_demux7 dut (
    .clk(clk), .rst(rst), .En(en), .Din(din), .Fsync(fsync), .Sel(sel),
    .A(a), .B(b), .C(c), .D(d), .E(e), .F(f), .G(g),
    .Frame_valid(frame_valid), .Sync_err(sync_err), .Locked(locked)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit v, input bit fs, input bit bit_in);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (r) begin
      m_locked = 1'b0;
      m_pos    = 0;
      foreach (m_part[i]) m_part[i] = 1'b0;
      foreach (m_out[i])  m_out[i]  = 1'b0;
    end else if (v) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked  = 1'b1;
          m_part[0] = bit_in;
          m_pos     = 1;
        end
      end else if (fs) begin
        if (m_pos != 0) m_se = 1'b1;
        foreach (m_part[i]) m_part[i] = 1'b0;
        m_part[0] = bit_in;
        m_pos     = 1;
      end else if (m_pos == 0) begin
        m_se     = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_part[m_pos] = bit_in;
        if (m_pos == 6) begin
          foreach (m_out[i]) m_out[i] = m_part[i];
          m_fv  = 1'b1;
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endfunction

  function automatic logic [6:0] exp_abcdefg();
    return {m_out[0], m_out[1], m_out[2], m_out[3], m_out[4], m_out[5], m_out[6]};
  endfunction

  task automatic cycle(input bit r, input bit v, input bit fs, input bit bit_in);
    rst = r; en = v; fsync = fs; din = bit_in;
    @(posedge clk);
    model_step(r, v, fs, bit_in);
    #1;
    check_val("sel",         {29'd0, sel},               m_pos);
    check_val("abcdefg",     {25'd0, a, b, c, d, e, f, g}, {25'd0, exp_abcdefg()});
    check_val("frame_valid", {31'd0, frame_valid},        {31'd0, m_fv});
    check_val("sync_err",    {31'd0, sync_err},           {31'd0, m_se});
    check_val("locked",      {31'd0, locked},             {31'd0, m_locked});
  endtask

  task automatic send_frame(input logic [6:0] bits_a2g);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, (i == 0), bits_a2g[6-i]);
  endtask

  initial begin
    logic [6:0] pat;
    pat = 7'b1011001;
    rst = 1'b1; en = 1'b0; fsync = 1'b0; din = 1'b0;
    m_locked = 1'b0; m_pos = 0;
    foreach (m_part[i]) m_part[i] = 1'b0;
    foreach (m_out[i])  m_out[i]  = 1'b0;

    // Reset then idle.
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_abcdefg", {25'd0, a, b, c, d, e, f, g}, 32'd0);

    // Single frame.
    send_frame(pat);
    check_val("frame1_value", {25'd0, a, b, c, d, e, f, g}, {25'd0, pat});
    check_val("frame1_fv",    {31'd0, frame_valid}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped frame: idle after slots 2 and 5.
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, (i == 0), pat[6-i]);
      if (i == 2 || i == 5) begin
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("gap_sel_hold", {29'd0, sel}, i + 1);
      end
    end
    check_val("gap_value", {25'd0, a, b, c, d, e, f, g}, {25'd0, pat});

    // Early sync at Sel=4, then complete the new frame.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, (i == 0), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("early_sync_err", {31'd0, sync_err}, 32'd1);
    check_val("early_sel",      {29'd0, sel}, 32'd1);
    check_val("early_keep",     {25'd0, a, b, c, d, e, f, g}, {25'd0, pat});
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("early_newframe", {25'd0, a, b, c, d, e, f, g}, 32'h3f);

    // Missing sync at Sel=0.
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check_val("miss_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, i[0]);

    // Reset mid-frame at Sel=3.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, (i == 0), 1'b1);
    check_val("pre_rst_sel", {29'd0, sel}, 32'd3);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_val("rst_abcdefg", {25'd0, a, b, c, d, e, f, g}, 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      bit r, v, fs;
      r  = ($urandom_range(0, 299) == 0);
      v  = ($urandom_range(0, 4) != 0);
      fs = (m_pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
      cycle(r, v, fs, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
